// File: rtl/number_analyzer_pkg.sv
// Shared definitions for number_analyzer.
//   - State encodings of the three classifier FSMs. The numeric values are
//     visible on the top-level state ports, so they must not be renumbered.
//   - RADIX: palindrome radix, 2 when NUMBER_ANALYZER_BINARY_PAL_EN is
//     defined, otherwise 10.
package number_analyzer_pkg;

  typedef enum logic [1:0] {
    EVEN_IDLE  = 2'd0,
    EVEN_CHECK = 2'd1,
    EVEN_EVEN  = 2'd2,
    EVEN_ODD   = 2'd3
  } even_state_t;

  typedef enum logic [3:0] {
    FIB_IDLE   = 4'd0,
    FIB_INIT   = 4'd1,
    FIB_CMP    = 4'd2,
    FIB_OVER   = 4'd3,
    FIB_ADD    = 4'd4,
    FIB_SHA    = 4'd5,
    FIB_SHB    = 4'd6,
    FIB_FIB    = 4'd7,
    FIB_NOTFIB = 4'd8
  } fib_state_t;

  // Codes 7 and 8 are deliberately unused so that NOTPAL reads as 9.
  typedef enum logic [3:0] {
    PAL_IDLE   = 4'd0,
    PAL_INIT   = 4'd1,
    PAL_LOOP   = 4'd2,
    PAL_DIGIT  = 4'd3,
    PAL_ACCUM  = 4'd4,
    PAL_CMP    = 4'd5,
    PAL_PAL    = 4'd6,
    PAL_NOTPAL = 4'd9
  } pal_state_t;

`ifdef NUMBER_ANALYZER_BINARY_PAL_EN
  localparam int RADIX = 2;
`else
  localparam int RADIX = 10;
`endif

endpackage

// File: rtl/number_analyzer_palindrome.sv
// Palindrome classifier: reverses the operand digit by digit and compares
// the reversal with the operand latched at start.
// Configuration macro: NUMBER_ANALYZER_BINARY_PAL_EN selects radix 2
// (bit reversal of the significant bits); otherwise radix 10.
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   go            in   run/hold level; low returns the FSM to IDLE
//   number        in   operand, latched when leaving IDLE
//   is_palindrome out  registered result, set on entering PAL
//   state         out  current FSM state code
module number_analyzer_palindrome
  import number_analyzer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [W-1:0] number,
  output logic         is_palindrome,
  output logic [3:0]   state
);

  pal_state_t   cur, nxt;
  logic [W-1:0] pal_num;
  logic [W-1:0] tmp;
  logic [W+1:0] rev;   // two spare bits: the reversal of a W-bit value can exceed W bits
  logic [3:0]   dig_r;
  logic [W-1:0] quo_r;
  logic [3:0]   dig_c;
  logic [W-1:0] quo_c;
  logic [W+1:0] rev_c;

`ifdef NUMBER_ANALYZER_BINARY_PAL_EN
  always_comb begin
    dig_c = {3'b000, tmp[0]};
    quo_c = tmp >> 1;
    rev_c = (rev << 1) | (W+2)'(dig_r);
  end
`else
  localparam logic [W-1:0] RAD     = W'(RADIX);
  localparam logic [W+1:0] REV_RAD = (W+2)'(RADIX);

  always_comb begin
    dig_c = 4'(tmp % RAD);
    quo_c = tmp / RAD;
    rev_c = rev * REV_RAD + (W+2)'(dig_r);
  end
`endif

  always_comb begin
    nxt = cur;
    case (cur)
      PAL_IDLE:   if (go) nxt = PAL_INIT;
      PAL_INIT:   nxt = go ? PAL_LOOP : PAL_IDLE;
      PAL_LOOP:   if (!go) nxt = PAL_IDLE;
                  else     nxt = (tmp == '0) ? PAL_CMP : PAL_DIGIT;
      PAL_DIGIT:  nxt = go ? PAL_ACCUM : PAL_IDLE;
      PAL_ACCUM:  nxt = go ? PAL_LOOP : PAL_IDLE;
      PAL_CMP:    if (!go) nxt = PAL_IDLE;
                  else     nxt = (rev == {2'b00, pal_num}) ? PAL_PAL : PAL_NOTPAL;
      PAL_PAL,
      PAL_NOTPAL: if (!go) nxt = PAL_IDLE;
      default:    nxt = PAL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= PAL_IDLE;
      pal_num       <= '0;
      tmp           <= '0;
      rev           <= '0;
      dig_r         <= '0;
      quo_r         <= '0;
      is_palindrome <= 1'b0;
    end else begin
      cur <= nxt;
      case (cur)
        PAL_IDLE: if (go) begin
          pal_num       <= number;
          is_palindrome <= 1'b0;
        end
        PAL_INIT: begin
          tmp <= pal_num;
          rev <= '0;
        end
        PAL_DIGIT: begin
          dig_r <= dig_c;
          quo_r <= quo_c;
        end
        PAL_ACCUM: begin
          rev <= rev_c;
          tmp <= quo_r;
        end
        default: ;
      endcase
      if (cur == PAL_CMP && nxt == PAL_PAL) is_palindrome <= 1'b1;
    end
  end

  assign state = cur;

endmodule

// File: rtl/number_analyzer.sv
// Classifies one unsigned operand three ways with independent FSMs that
// start together on go_i and finish at different times: even/odd,
// Fibonacci membership and palindrome (decimal, or binary when
// NUMBER_ANALYZER_BINARY_PAL_EN is defined).
// Ports:
//   clk                   in   clock, rising edge
//   reset                 in   asynchronous active-high reset
//   go_i                  in   run/hold level; low returns all FSMs to IDLE
//   number                in   operand (W bits), latched when each FSM leaves IDLE
//   isEven                out  registered even flag
//   isFibonacci           out  registered Fibonacci flag
//   isPalindrome          out  registered palindrome flag
//   stuckStateEven        out  even FSM state code (2 bits)
//   stuckStateFibonacci   out  Fibonacci FSM state code (4 bits)
//   stuckStatePalindrome  out  palindrome FSM state code (4 bits)
module number_analyzer
  import number_analyzer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go_i,
  input  logic [W-1:0] number,
  output logic         isEven,
  output logic         isFibonacci,
  output logic         isPalindrome,
  output logic [1:0]   stuckStateEven,
  output logic [3:0]   stuckStateFibonacci,
  output logic [3:0]   stuckStatePalindrome
);

  // Even/odd FSM
  even_state_t even_state, even_next;
  logic        even_bit;

  always_comb begin
    even_next = even_state;
    case (even_state)
      EVEN_IDLE:  if (go_i) even_next = EVEN_CHECK;
      EVEN_CHECK: if (!go_i) even_next = EVEN_IDLE;
                  else       even_next = even_bit ? EVEN_ODD : EVEN_EVEN;
      EVEN_EVEN,
      EVEN_ODD:   if (!go_i) even_next = EVEN_IDLE;
      default:    even_next = EVEN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      even_state <= EVEN_IDLE;
      even_bit   <= 1'b0;
      isEven     <= 1'b0;
    end else begin
      even_state <= even_next;
      if (even_state == EVEN_IDLE && go_i) begin
        even_bit <= number[0];
        isEven   <= 1'b0;
      end
      if (even_state == EVEN_CHECK && even_next == EVEN_EVEN) isEven <= 1'b1;
    end
  end

  assign stuckStateEven = even_state;

  // Fibonacci FSM: walks a through the sequence until it meets or passes n.
  // a, b, t carry one extra bit so the largest term needed (F49) never wraps.
  fib_state_t   fib_state, fib_next;
  logic [W-1:0] fib_n;
  logic [W:0]   fib_a, fib_b, fib_t;

  always_comb begin
    fib_next = fib_state;
    case (fib_state)
      FIB_IDLE:   if (go_i) fib_next = FIB_INIT;
      FIB_INIT:   fib_next = go_i ? FIB_CMP : FIB_IDLE;
      FIB_CMP:    if (!go_i) fib_next = FIB_IDLE;
                  else       fib_next = (fib_a == {1'b0, fib_n}) ? FIB_FIB : FIB_OVER;
      FIB_OVER:   if (!go_i) fib_next = FIB_IDLE;
                  else       fib_next = (fib_a > {1'b0, fib_n}) ? FIB_NOTFIB : FIB_ADD;
      FIB_ADD:    fib_next = go_i ? FIB_SHA : FIB_IDLE;
      FIB_SHA:    fib_next = go_i ? FIB_SHB : FIB_IDLE;
      FIB_SHB:    fib_next = go_i ? FIB_CMP : FIB_IDLE;
      FIB_FIB,
      FIB_NOTFIB: if (!go_i) fib_next = FIB_IDLE;
      default:    fib_next = FIB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fib_state   <= FIB_IDLE;
      fib_n       <= '0;
      fib_a       <= '0;
      fib_b       <= '0;
      fib_t       <= '0;
      isFibonacci <= 1'b0;
    end else begin
      fib_state <= fib_next;
      case (fib_state)
        FIB_IDLE: if (go_i) begin
          fib_n       <= number;
          isFibonacci <= 1'b0;
        end
        FIB_INIT: begin
          fib_a <= '0;
          fib_b <= (W+1)'(1);
        end
        FIB_ADD: fib_t <= fib_a + fib_b;
        FIB_SHA: fib_a <= fib_b;
        FIB_SHB: fib_b <= fib_t;
        default: ;
      endcase
      if (fib_state == FIB_CMP && fib_next == FIB_FIB) isFibonacci <= 1'b1;
    end
  end

  assign stuckStateFibonacci = fib_state;

  // Palindrome FSM and its radix datapath
  number_analyzer_palindrome #(
    .W (W)
  ) u_pal (
    .clk           (clk),
    .reset         (reset),
    .go            (go_i),
    .number        (number),
    .is_palindrome (isPalindrome),
    .state         (stuckStatePalindrome)
  );

endmodule

// File: tb/tb_number_analyzer.sv
// Directed bench for number_analyzer: classification results, completion
// latencies, hold/return-to-IDLE handshake, abort and asynchronous reset.
module tb_number_analyzer;

  logic        clk;
  logic        reset;
  logic        go_i;
  logic [31:0] number;
  logic        isEven, isFibonacci, isPalindrome;
  logic [1:0]  stuckStateEven;
  logic [3:0]  stuckStateFibonacci;
  logic [3:0]  stuckStatePalindrome;

  int checks = 0;
  int errors = 0;

  number_analyzer #(.W(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .go_i                 (go_i),
    .number               (number),
    .isEven               (isEven),
    .isFibonacci          (isFibonacci),
    .isPalindrome         (isPalindrome),
    .stuckStateEven       (stuckStateEven),
    .stuckStateFibonacci  (stuckStateFibonacci),
    .stuckStatePalindrome (stuckStatePalindrome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] se, input logic [3:0] sf,
                           input logic [3:0] sp, input logic fe, input logic ff, input logic fp);
    check({tag, "_st_even"}, 64'(stuckStateEven), 64'(se));
    check({tag, "_st_fib"},  64'(stuckStateFibonacci), 64'(sf));
    check({tag, "_st_pal"},  64'(stuckStatePalindrome), 64'(sp));
    check({tag, "_isEven"},  64'(isEven), 64'(fe));
    check({tag, "_isFib"},   64'(isFibonacci), 64'(ff));
    check({tag, "_isPal"},   64'(isPalindrome), 64'(fp));
  endtask

  // Raise go_i with an operand, record the first cycle each FSM shows a
  // done code, check results and latencies, then drop go_i for one cycle.
  task automatic run_case(input string tag, input logic [31:0] num,
                          input logic fe, input logic ff, input logic fp,
                          input logic [1:0] se, input logic [3:0] sf, input logic [3:0] sp,
                          input int le_exp, input int lf_exp, input int lp_exp);
    int le, lf, lp, c;
    le = 0; lf = 0; lp = 0; c = 0;
    @(negedge clk);
    number = num;
    go_i   = 1'b1;
    while ((le == 0 || lf == 0 || lp == 0) && c < 400) begin
      @(posedge clk); #1;
      c++;
      if (le == 0 && stuckStateEven >= 2'd2) le = c;
      if (lf == 0 && stuckStateFibonacci >= 4'd7) lf = c;
      if (lp == 0 && (stuckStatePalindrome == 4'd6 || stuckStatePalindrome == 4'd9)) lp = c;
    end
    check({tag, "_lat_even"}, 64'(le), 64'(le_exp));
    check({tag, "_lat_fib"},  64'(lf), 64'(lf_exp));
    check({tag, "_lat_pal"},  64'(lp), 64'(lp_exp));
    check_all({tag, "_done"}, se, sf, sp, fe, ff, fp);
    @(negedge clk);
    go_i = 1'b0;
    @(posedge clk); #1;
    check_all({tag, "_idle"}, 2'd0, 4'd0, 4'd0, fe, ff, fp);
  endtask

  initial begin
    reset  = 1'b1;
    go_i   = 1'b0;
    number = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 55 = F10, two decimal digits
    run_case("n55", 32'd55, 1'b0, 1'b1, 1'b1, 2'd3, 4'd7, 4'd6, 2, 53, 10);
    // 0 = F0, no digits
    run_case("n0", 32'd0, 1'b1, 1'b1, 1'b1, 2'd2, 4'd7, 4'd6, 2, 3, 4);
    // 144 = F12, reverses to 441
    run_case("n144", 32'd144, 1'b1, 1'b1, 1'b0, 2'd2, 4'd7, 4'd9, 2, 63, 13);
    // 121: F12=144 is the first term above it
    run_case("n121", 32'd121, 1'b0, 1'b0, 1'b1, 2'd3, 4'd8, 4'd6, 2, 64, 13);
    // all ones: F48 first term above, 10 digits, reversal 5927694924
    run_case("nmax", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'd3, 4'd8, 4'd9, 2, 244, 34);

    // Abort while Fibonacci and palindrome FSMs are still busy
    @(negedge clk);
    number = 32'd144;
    go_i   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_even_done", 64'(stuckStateEven), 64'd2);
    @(negedge clk);
    go_i = 1'b0;
    @(posedge clk); #1;
    check_all("abort", 2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    number = 32'd144;
    go_i   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_isEven", 64'(isEven), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    go_i  = 1'b0;

    // Re-raise go_i with 8 = F6, single decimal digit
    run_case("n8", 32'd8, 1'b1, 1'b1, 1'b1, 2'd2, 4'd7, 4'd6, 2, 33, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
